spike_rate_encoder: RTL and testbench
=====================================

Name: spike_rate_encoder

Overview:
- Transmit end of the neuron's spike-input interface: converts per-channel intensity values into deterministic rate-coded spike trains.
- Drives the neuron's `x` inputs.
- Each channel uses a phase-accumulator (first-order sigma-delta). Over one window of 2**VALUE_BITS ticks, a channel emits exactly as many spikes as its programmed value.
- Values are loaded one channel at a time while idle. A `start` pulse launches one window.

Parameters:
- CHANNELS, 4, number of spike outputs (matches neuron input count).
- VALUE_BITS, 4, intensity width per channel. Window length WINDOW = 2**VALUE_BITS ticks (derived localparam, 16 by default).

Ports:
- clk  input  1  clock.
- reset  input  1  reset, synchronous, active-high.
- cfg_valid  input  1  request to write one channel value.
- cfg_ready  output  1  high only in IDLE; a write occurs on a clk edge where cfg_valid && cfg_ready.
- cfg_ch  input  $clog2(CHANNELS)  target channel index.
- cfg_value  input  VALUE_BITS  intensity for that channel (0..2**VALUE_BITS-1).
- start  input  1  begin one encoding window (sampled only in IDLE).
- busy  output  1  high in RUN and DONE.
- spikes  output  CHANNELS  registered spike vector, bit i = channel i.
- spike_valid  output  1  high while spikes holds a fresh tick sample.
- done  output  1  one-cycle pulse, coincident with the last sample of the window.
- tick_count  output  VALUE_BITS  ticks completed in the current window (wraps to 0 after the last tick).

Behaviour:

Reset:
- state = IDLE.
- All value registers, accumulators, spikes, spike_valid, done and tick_count = 0.
- busy = 0; cfg_ready = 1 from the first cycle after reset.
- Reset mid-RUN or in DONE aborts immediately. No done pulse is issued and programmed values are lost.

FSM states: IDLE, RUN, DONE.

IDLE:
- cfg write: value[cfg_ch] <= cfg_value. A cfg_ch >= CHANNELS is accepted but discarded.
- start = 1 moves to RUN at the same edge: accumulators <= 0, tick_count <= 0; spikes, spike_valid and done stay 0.
- cfg write and start on the same edge: the write commits, and the window uses the new value.

RUN, at each edge (tick k = 1..WINDOW):
- {carry_i, acc_i} <= acc_i + value_i, computed VALUE_BITS+1 wide.
- spikes[i] <= carry_i.
- spike_valid <= 1.
- tick_count <= tick_count + 1 (mod WINDOW).
- At tick WINDOW, state <= DONE and done <= 1.
- The window therefore contributes exactly value_i spikes on channel i.

DONE (one cycle):
- spikes holds tick WINDOW's sample; spike_valid = 1; done = 1.
- Next edge: IDLE, spikes <= 0, spike_valid <= 0, done <= 0.

Ignored inputs:
- start and cfg_valid are ignored while busy (cfg_ready = 0).
- start asserted in the DONE cycle is ignored. A new window needs start in IDLE, so the minimum window-to-window gap is 1 IDLE cycle.

Latency and timing:
- start edge to first sample visible: 1 cycle.
- Samples visible for WINDOW consecutive cycles.
- busy is high for WINDOW + 1 cycles after the start edge (WINDOW RUN cycles plus the DONE cycle).

Arithmetic and boundary values:
- No saturation is needed; the accumulator wraps mod 2**VALUE_BITS by construction.
- value 0 never spikes.
- value 2**VALUE_BITS-1 spikes on every tick except tick 1.
- Values persist across windows until rewritten or reset.
- Spike timing is identical for every window with the same values, because accumulators clear at each start.

Test Plan:
- Reset, program ch0=4, ch1=8, ch2=1, ch3=0, pulse start:
  - ch0 spikes at ticks 4,8,12,16.
  - ch1 spikes at every even tick.
  - ch2 spikes at tick 16 only; ch3 never spikes.
  - done high on tick 16's cycle, coincident with spike_valid; busy high for 17 cycles.
- Program all channels = 15, run a window:
  - Each channel produces 15 spikes; tick 1 is 0000 and ticks 2..16 are 1111.
  - tick_count reads 1..15 then 0 at done.
- cfg_valid with ch1=5 held during RUN:
  - cfg_ready = 0 and the write is ignored.
  - Next window still uses the old value; a write after returning to IDLE takes effect.
- start and cfg_valid(ch0=3) on the same IDLE edge:
  - Window uses 3: ch0 spikes at ticks 6,11,16.
  - start re-pulsed during RUN and during the DONE cycle is ignored (no restart, single done).
- Assert reset at tick 7 of a window:
  - Next cycle spikes = 0, spike_valid = 0, busy = 0, done never pulses.
  - All values read back as 0: a fresh window with no writes emits no spikes.
- Back-to-back windows with start held high continuously:
  - Windows repeat with exactly one IDLE cycle between them.
  - Spike patterns are identical each window.

Source files
------------

// File: rtl/spike_rate_encoder.sv
// -----------------------------------------------------------------------------
// spike_rate_encoder
//
// Transmit end of a neuron's spike-input interface. Each channel holds an
// intensity value and, during one encoding window of 2**VALUE_BITS ticks,
// emits a deterministic rate-coded spike train with exactly `value` spikes.
// Every channel is a first-order sigma-delta: a VALUE_BITS-wide phase
// accumulator whose carry-out on each tick is the spike.
//
// Channel values are written one at a time while idle. A start pulse in IDLE
// launches one window. Accumulators clear at every start, so the same values
// always produce the same spike timing.
//
// Ports
//   clk          clock
//   reset        synchronous, active-high reset
//   cfg_valid    request to write one channel value
//   cfg_ready    high only in IDLE; a write happens when cfg_valid && cfg_ready
//   cfg_ch       target channel (indices >= CHANNELS are accepted, then dropped)
//   cfg_value    intensity for that channel
//   start        launch one window (sampled only in IDLE)
//   busy         high in RUN and DONE
//   spikes       registered spike vector, bit i = channel i
//   spike_valid  spikes holds a fresh tick sample
//   done         one-cycle pulse together with the last sample of the window
//   tick_count   ticks completed in the current window (wraps to 0 at the end)
// -----------------------------------------------------------------------------
module spike_rate_encoder #(
  parameter int CHANNELS   = 4,
  parameter int VALUE_BITS = 4
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        cfg_valid,
  output logic                        cfg_ready,
  input  logic [$clog2(CHANNELS)-1:0] cfg_ch,
  input  logic [VALUE_BITS-1:0]       cfg_value,
  input  logic                        start,
  output logic                        busy,
  output logic [CHANNELS-1:0]         spikes,
  output logic                        spike_valid,
  output logic                        done,
  output logic [VALUE_BITS-1:0]       tick_count
);

  localparam int                    WINDOW    = 2 ** VALUE_BITS;
  // tick_count holds the number of completed ticks; seeing WINDOW-1 in RUN
  // means the edge about to happen is the final tick of the window.
  localparam logic [VALUE_BITS-1:0] LAST_TICK = VALUE_BITS'(WINDOW - 1);
  localparam logic [VALUE_BITS-1:0] ONE_TICK  = VALUE_BITS'(1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  logic [VALUE_BITS-1:0] value_q [CHANNELS];
  logic [VALUE_BITS-1:0] acc_q   [CHANNELS];

  // Per-channel accumulator sums, one bit wider than the accumulator so the
  // top bit is the carry (the spike) and the low bits wrap naturally.
  logic [VALUE_BITS:0]   sum     [CHANNELS];
  logic [CHANNELS-1:0]   carry;

  logic cfg_accept;
  logic last_tick;

  // ---------------------------------------------------------------------------
  // Handshake / status outputs are pure decodes of the state.
  // ---------------------------------------------------------------------------
  assign cfg_ready = (state_q == S_IDLE);
  assign busy      = (state_q != S_IDLE);

  // Writes to a channel index that does not exist are acknowledged but have
  // no effect, so the producer never stalls on a bad index.
  assign cfg_accept = cfg_valid && cfg_ready && (int'(cfg_ch) < CHANNELS);

  assign last_tick  = (state_q == S_RUN) && (tick_count == LAST_TICK);

  // ---------------------------------------------------------------------------
  // Phase accumulators: sum = acc + value, carry-out becomes the spike.
  // ---------------------------------------------------------------------------
  // NOTE: combinational blocks use blocking '=' so later statements see the
  // freshly computed value; clocked blocks use '<=' so every register samples
  // the pre-edge values regardless of statement order.
  always_comb begin
    for (int i = 0; i < CHANNELS; i++) begin
      sum[i]   = {1'b0, acc_q[i]} + {1'b0, value_q[i]};
      carry[i] = sum[i][VALUE_BITS];
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next-state logic
  // ---------------------------------------------------------------------------
  // NOTE: assigning the default before the case guarantees state_d is written
  // on every path, so no latch is inferred for a missing branch.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:  if (start)     state_d = S_RUN;
      S_RUN:   if (last_tick) state_d = S_DONE;
      S_DONE:                 state_d = S_IDLE;   // start is ignored here
      default:                state_d = S_IDLE;
    endcase
  end

  // ---------------------------------------------------------------------------
  // Datapath: channel values, accumulators and the registered outputs.
  // ---------------------------------------------------------------------------
  // NOTE: the value array is reset explicitly because programmed values must
  // read as zero after a reset; this keeps it in flops rather than a RAM macro.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < CHANNELS; i++) begin
        value_q[i] <= '0;
        acc_q[i]   <= '0;
      end
      spikes      <= '0;
      spike_valid <= 1'b0;
      done        <= 1'b0;
      tick_count  <= '0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          // A write and a start on the same edge both take effect; the first
          // tick reads value_q one edge later, so it already sees the write.
          if (cfg_accept) begin
            value_q[cfg_ch] <= cfg_value;
          end
          if (start) begin
            for (int i = 0; i < CHANNELS; i++) begin
              acc_q[i] <= '0;
            end
            tick_count <= '0;
          end
          spikes      <= '0;
          spike_valid <= 1'b0;
          done        <= 1'b0;
        end

        S_RUN: begin
          for (int i = 0; i < CHANNELS; i++) begin
            acc_q[i] <= sum[i][VALUE_BITS-1:0];
          end
          spikes      <= carry;
          spike_valid <= 1'b1;
          tick_count  <= tick_count + ONE_TICK;   // wraps to 0 on the last tick
          done        <= last_tick;
        end

        S_DONE: begin
          // Last sample was shown for exactly this one cycle; drop back to
          // an all-quiet output while idle.
          spikes      <= '0;
          spike_valid <= 1'b0;
          done        <= 1'b0;
        end

        default: begin
          spikes      <= '0;
          spike_valid <= 1'b0;
          done        <= 1'b0;
          tick_count  <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_spike_rate_encoder.sv
// -----------------------------------------------------------------------------
// tb_spike_rate_encoder
//
// Directed bench for spike_rate_encoder (default CHANNELS=4, VALUE_BITS=4).
// A cycle-level reference model tracks the window phase and computes each
// channel's spike directly from the rate-coding rule:
//   spike on tick k  <=>  floor(k*v/W) != floor((k-1)*v/W)
// A compare process checks all outputs against it every cycle after reset.
// Hand-computed tick masks (bit k-1 = spike on tick k) pin the model.
// -----------------------------------------------------------------------------
module tb_spike_rate_encoder;

  localparam int CHANNELS   = 4;
  localparam int VALUE_BITS = 4;
  localparam int WINDOW     = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       cfg_valid = 1'b0;
  logic       cfg_ready;
  logic [1:0] cfg_ch = 2'd0;
  logic [3:0] cfg_value = 4'd0;
  logic       start = 1'b0;
  logic       busy;
  logic [3:0] spikes;
  logic       spike_valid;
  logic       done;
  logic [3:0] tick_count;

  always #5 clk = ~clk;

  spike_rate_encoder #(
    .CHANNELS  (CHANNELS),
    .VALUE_BITS(VALUE_BITS)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .cfg_valid  (cfg_valid),
    .cfg_ready  (cfg_ready),
    .cfg_ch     (cfg_ch),
    .cfg_value  (cfg_value),
    .start      (start),
    .busy       (busy),
    .spikes     (spikes),
    .spike_valid(spike_valid),
    .done       (done),
    .tick_count (tick_count)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model. m_phase = -1 idle, otherwise number of ticks emitted so
  // far in the window (0..16; 16 is the DONE cycle).
  // ---------------------------------------------------------------------------
  int m_phase = -1;
  int m_vals [CHANNELS];
  bit cmp_en = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_phase <= -1;
      for (int i = 0; i < CHANNELS; i++) m_vals[i] <= 0;
    end else if (m_phase < 0) begin
      if (cfg_valid && int'(cfg_ch) < CHANNELS) m_vals[cfg_ch] <= int'(cfg_value);
      if (start) m_phase <= 0;
    end else if (m_phase == WINDOW) begin
      m_phase <= -1;
    end else begin
      m_phase <= m_phase + 1;
    end
  end

  // {cfg_ready, busy, spike_valid, done, tick_count[3:0], spikes[3:0]}
  function automatic logic [11:0] model_out();
    logic [3:0] sp = 4'd0;
    logic [3:0] tc = 4'd0;
    if (m_phase >= 1) begin
      for (int i = 0; i < CHANNELS; i++)
        sp[i] = ((m_phase * m_vals[i]) / WINDOW) != (((m_phase - 1) * m_vals[i]) / WINDOW);
    end
    if (m_phase >= 0) tc = 4'(m_phase % WINDOW);
    return {m_phase < 0, m_phase >= 0, m_phase >= 1, m_phase == WINDOW, tc, sp};
  endfunction

  always @(posedge clk) begin
    #1;
    if (cmp_en)
      check("cycle_outputs",
            {20'd0, cfg_ready, busy, spike_valid, done, tick_count, spikes},
            {20'd0, model_out()});
  end

  // ---------------------------------------------------------------------------
  // Capture buffer: one entry per cycle, sampled at the falling edge.
  // ---------------------------------------------------------------------------
  bit         cap_busy [64];
  bit         cap_sv   [64];
  bit         cap_done [64];
  bit         cap_rdy  [64];
  logic [3:0] cap_spk  [64];
  logic [3:0] cap_tc   [64];

  task automatic capture(input int n, input bit poke_start, input bit poke_cfg);
    for (int c = 0; c < n; c++) begin
      cap_busy[c] = busy;
      cap_sv[c]   = spike_valid;
      cap_done[c] = done;
      cap_rdy[c]  = cfg_ready;
      cap_spk[c]  = spikes;
      cap_tc[c]   = tick_count;
      if (poke_start) start = busy;
      if (poke_cfg) begin
        cfg_valid = busy;
        cfg_ch    = 2'd1;
        cfg_value = 4'd5;
      end
      @(negedge clk);
    end
    if (poke_start) start = 1'b0;
    if (poke_cfg) cfg_valid = 1'b0;
  endtask

  // Tick mask of a channel for the window whose start edge precedes cap[base].
  function automatic logic [15:0] mask_of(input int ch, input int base);
    logic [15:0] m = '0;
    for (int s = 1; s <= WINDOW; s++)
      if (cap_sv[base + s]) m[s-1] = cap_spk[base + s][ch];
    return m;
  endfunction

  function automatic int count_busy(input int first, input int last);
    int n = 0;
    for (int c = first; c <= last; c++) n += int'(cap_busy[c]);
    return n;
  endfunction

  function automatic int count_done(input int first, input int last);
    int n = 0;
    for (int c = first; c <= last; c++) n += int'(cap_done[c]);
    return n;
  endfunction

  task automatic do_reset();
    reset = 1'b1; cfg_valid = 1'b0; start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic cfg_write(input int ch, input int val);
    cfg_valid = 1'b1; cfg_ch = 2'(ch); cfg_value = 4'(val);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  task automatic launch();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed sequence
  // ---------------------------------------------------------------------------
  initial begin
    @(negedge clk);
    do_reset();
    cmp_en = 1'b1;

    // Reset state
    check("rst_cfg_ready",   cfg_ready,   1);
    check("rst_busy",        busy,        0);
    check("rst_spikes",      spikes,      0);
    check("rst_spike_valid", spike_valid, 0);
    check("rst_done",        done,        0);
    check("rst_tick_count",  tick_count,  0);

    // Window with 4, 8, 1, 0
    cfg_write(0, 4); cfg_write(1, 8); cfg_write(2, 1); cfg_write(3, 0);
    launch();
    capture(20, 1'b0, 1'b0);
    check("w1_ch0_mask",   mask_of(0, 0), 32'h8888);
    check("w1_ch1_mask",   mask_of(1, 0), 32'hAAAA);
    check("w1_ch2_mask",   mask_of(2, 0), 32'h8000);
    check("w1_ch3_mask",   mask_of(3, 0), 32'h0000);
    check("w1_no_sample0", cap_sv[0], 0);
    check("w1_busy_len",   count_busy(0, 19), 17);
    check("w1_done_count", count_done(0, 19), 1);
    check("w1_done_last",  cap_done[16] & cap_sv[16], 1);

    // All channels at full scale
    for (int ch = 0; ch < CHANNELS; ch++) cfg_write(ch, 15);
    launch();
    capture(20, 1'b0, 1'b0);
    for (int ch = 0; ch < CHANNELS; ch++) begin
      check($sformatf("full_ch%0d_mask", ch), mask_of(ch, 0), 32'hFFFE);
      check($sformatf("full_ch%0d_count", ch), $countones(mask_of(ch, 0)), 15);
    end
    for (int k = 1; k <= WINDOW; k++)
      check($sformatf("full_tick_count_%0d", k), cap_tc[k], k % WINDOW);

    // Config write attempted during RUN/DONE is refused
    launch();
    capture(20, 1'b0, 1'b1);
    check("busy_write_ready", count_busy(0, 19) - 17, 0);
    begin
      int rdy_while_busy = 0;
      for (int c = 0; c < 20; c++) rdy_while_busy += int'(cap_busy[c] & cap_rdy[c]);
      check("busy_ready_low", rdy_while_busy, 0);
    end
    launch();
    capture(20, 1'b0, 1'b0);
    check("busy_write_ignored", mask_of(1, 0), 32'hFFFE);
    cfg_write(1, 5);
    launch();
    capture(20, 1'b0, 1'b0);
    check("idle_write_ch1_5", mask_of(1, 0), 32'h9248);

    // Write and start on the same edge; start re-pulsed in RUN and DONE
    cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_value = 4'd3; start = 1'b1;
    @(negedge clk);
    cfg_valid = 1'b0; start = 1'b0;
    capture(24, 1'b1, 1'b0);
    check("same_edge_ch0_mask", mask_of(0, 0), 32'h8420);
    check("restart_busy_len",   count_busy(0, 23), 17);
    check("restart_done_count", count_done(0, 23), 1);
    check("restart_idle_after", cap_busy[17], 0);

    // Reset in the middle of a window
    launch();
    capture(7, 1'b0, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_spikes",      spikes,      0);
    check("abort_spike_valid", spike_valid, 0);
    check("abort_busy",        busy,        0);
    check("abort_done",        done,        0);
    check("abort_ready",       cfg_ready,   1);
    check("abort_no_done",     count_done(0, 6), 0);
    launch();
    capture(20, 1'b0, 1'b0);
    for (int ch = 0; ch < CHANNELS; ch++)
      check($sformatf("abort_cleared_ch%0d", ch), mask_of(ch, 0), 32'h0000);
    check("abort_fresh_done", count_done(0, 19), 1);

    // Back-to-back windows with start held high
    cfg_write(0, 4); cfg_write(1, 15); cfg_write(2, 3); cfg_write(3, 0);
    start = 1'b1;
    @(negedge clk);
    capture(40, 1'b0, 1'b0);
    start = 1'b0;
    check("b2b_gap1",      cap_busy[17], 0);
    check("b2b_restart",   cap_busy[18], 1);
    check("b2b_gap2",      cap_busy[35], 0);
    check("b2b_busy_span", count_busy(0, 35), 34);
    check("b2b_w1_ch0",    mask_of(0, 0),  32'h8888);
    check("b2b_w1_ch1",    mask_of(1, 0),  32'hFFFE);
    check("b2b_w1_ch2",    mask_of(2, 0),  32'h8420);
    check("b2b_w1_ch3",    mask_of(3, 0),  32'h0000);
    for (int ch = 0; ch < CHANNELS; ch++)
      check($sformatf("b2b_repeat_ch%0d", ch), mask_of(ch, 18), mask_of(ch, 0));

    // Let the third window (started by the held start) drain, bounded.
    begin
      int guard = 0;
      while (busy && guard < 40) begin
        @(negedge clk);
        guard++;
      end
      check("drain_idle", busy, 0);
    end

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
